logic_gate_unit: RTL and testbench
==================================

Name: logic_gate_unit

Overview:
- Parametrised, registered successor to the team's 1-bit combinational AND gate.
- Applies one of eight bitwise logic ops to two WIDTH-bit operands and returns the result through a valid/ready stream stage with backpressure.
- Also returns per-result reduction flags and a saturating transaction counter.
- Sits between operand producers and downstream datapath or test logic as a reusable gate primitive.

Parameters:
- WIDTH, 8: operand and result width in bits (>=1).
- CNT_W, 16: width of the transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select, sampled with the beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- c  out  WIDTH  result.
- c_all  out  1  AND-reduce of c.
- c_any  out  1  OR-reduce of c.
- txn_cnt  out  CNT_W  count of accepted input beats, saturating.

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: out_valid=0, c=0, c_all=0, c_any=0, txn_cnt=0. in_ready=1 in the first cycle after reset.
- Op encoding:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XNOR: ~(a^b)
  - 6 ANDN: a&~b
  - 7 PASS: a
- All ops are full WIDTH; no carries, no truncation.
- Input handshake: a beat is accepted when in_valid && in_ready at a clock edge. a, b and op are sampled only on acceptance.
- Output handshake: a result is consumed when out_valid && out_ready.
- c, c_all and c_any are held stable while out_valid=1 && out_ready=0.
- Base build: single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Latency is 1 cycle from acceptance to out_valid.
  - Throughput is one beat per cycle when out_ready is held high.
- Simultaneous accept and consume in the same cycle: the register loads the new result and out_valid stays 1.
- Consume with no accept: out_valid clears to 0 next cycle.
- c_all and c_any are registered together with c, so they always describe the current c.
- Counter:
  - txn_cnt increments by 1 on every accepted beat.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It is cleared only by rst.
- rst during a stalled transfer discards the held result; no beat is replayed.
- in_valid asserted during the reset cycle is ignored.
- X on a, b or op while in_valid=0 must not propagate to any output.

Optional Feature:
- Macro: LOGIC_GATE_UNIT_SKID_EN.
- When defined:
  - A 2-entry skid buffer replaces the output register.
  - in_ready is a direct register output and depends on no input combinationally.
  - in_ready = !(skid entry occupied).
  - Latency is still 1 cycle; full throughput is kept.
  - When out_ready drops, one extra beat may be accepted into the skid entry and is emitted after the main entry, preserving order.
- When undefined: base single-register behaviour described above.

Decomposition:
- Shared package logic_gate_pkg holds:
  - the op_e typedef (3-bit enum, the eight encodings above)
  - the OP_W=3 constant
  - a function apply_op(a, b, op) used by both RTL and the bench reference model.
- Sub-module logic_gate_skid is natural: a generic WIDTH+2-bit valid/ready stage, instantiated either as a plain register or a 2-entry skid, depending on LOGIC_GATE_UNIT_SKID_EN.

Test Plan:
- Reset, then a=8'hF0, b=8'h3C with each op 0..7 and out_ready=1. Required c, one cycle after each accept:
  - 30, FC, CC, CF, 03, 33, C0, F0
  - c_all=0 for every op.
  - c_any=1 for every op.
  - txn_cnt=8.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 and a stream of 4 distinct beats.
  - c holds its first value.
  - Base build: in_ready=0 after the first accept.
  - SKID build: exactly 2 beats accepted.
  - On release, results emerge in order with no loss or duplication.
- Reduction: a=b=8'hFF, op=AND -> c=FF, c_all=1, c_any=1. Then op=XOR -> c=00, c_all=0, c_any=0.
- Saturation with CNT_W=4: 20 back-to-back accepts -> txn_cnt stops at 15 and does not wrap.
- Reset mid-stall: hold one result with out_ready=0, assert rst for 1 cycle -> next cycle out_valid=0, txn_cnt=0, in_ready=1.
- Random stream of 1000 beats with random in_valid/out_ready, checked against apply_op in both macro builds -> zero mismatches and zero ordering errors.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op encoding and the reference
// bitwise operation used by both the datapath and its bench model.
package logic_gate_pkg;

   localparam int OP_W  = 3;
   localparam int MAX_W = 256;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_ANDN = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   // Operands are zero-extended to MAX_W by the caller; callers truncate the result.
   function automatic logic [MAX_W-1:0] apply_op(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input op_e op);
      logic [MAX_W-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_ANDN: r = a & ~b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_gate_skid.sv
// Generic valid/ready stage: a single output register (SKID=0) or a 2-entry
// skid buffer whose in_ready is purely register-derived (SKID=1).
module logic_gate_skid #(
   parameter int W    = 10,
   parameter bit SKID = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] data_p0;
   logic         vld_p0;
   logic         accept;
   logic         consume;

   assign accept    = in_valid && in_ready;
   assign consume   = vld_p0 && out_ready;
   assign out_valid = vld_p0;
   assign out_data  = data_p0;

   generate
      if (SKID) begin : g_skid
         logic [W-1:0] data_p1;
         logic         vld_p1;

         assign in_ready = !vld_p1;

         // Main entry p0 drives the output; p1 catches the one beat that lands while stalled.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p0  <= 1'b0;
               vld_p1  <= 1'b0;
               data_p0 <= '0;
               data_p1 <= '0;
            end else if (!vld_p0 || consume) begin
               if (vld_p1) begin
                  data_p0 <= data_p1;
                  vld_p0  <= 1'b1;
                  vld_p1  <= 1'b0;
               end else if (accept) begin
                  data_p0 <= in_data;
                  vld_p0  <= 1'b1;
               end else begin
                  vld_p0  <= 1'b0;
               end
            end else if (accept) begin
               data_p1 <= in_data;
               vld_p1  <= 1'b1;
            end
         end
      end else begin : g_reg
         assign in_ready = !vld_p0 || out_ready;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p0  <= 1'b0;
               data_p0 <= '0;
            end else if (accept) begin
               data_p0 <= in_data;
               vld_p0  <= 1'b1;
            end else if (consume) begin
               vld_p0  <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshake, reduction
// flags and a saturating beat counter. Define LOGIC_GATE_UNIT_SKID_EN for a 2-entry skid output.
module logic_gate_unit
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             c_all,
   output logic             c_any,
   output logic [CNT_W-1:0] txn_cnt
);

`ifdef LOGIC_GATE_UNIT_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic [WIDTH-1:0] res;
   logic [WIDTH+1:0] res_pkt;
   logic [WIDTH+1:0] out_pkt;
   logic             accept;

   assign res     = WIDTH'(apply_op(MAX_W'(a), MAX_W'(b), op_e'(op)));
   assign res_pkt = {&res, |res, res};
   assign accept  = in_valid && in_ready;

   logic_gate_skid #(
      .W    (WIDTH + 2),
      .SKID (SKID)
   ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (res_pkt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pkt)
   );

   assign c     = out_pkt[WIDTH-1:0];
   assign c_any = out_pkt[WIDTH];
   assign c_all = out_pkt[WIDTH+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         txn_cnt <= '0;
      end else if (accept && (txn_cnt != {CNT_W{1'b1}})) begin
         txn_cnt <= txn_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed-vector and stream bench for logic_gate_unit (base and skid builds).
module tb_logic_gate_unit;
   import logic_gate_pkg::*;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LOGIC_GATE_UNIT_SKID_EN
   localparam int STALL_ACC = 2;
`else
   localparam int STALL_ACC = 1;
`endif

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [OP_W-1:0]  op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             c_all;
   logic             c_any;
   logic [CNT_W-1:0] txn_cnt;

   logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .c_all     (c_all),
      .c_any     (c_any),
      .txn_cnt   (txn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream scoreboard and counter model, evaluated just before each rising edge.
   logic [WIDTH-1:0] exp_q[$];
   int               cnt_model  = 0;
   int               acc_total  = 0;
   bit               mon_en     = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            exp_q.delete();
            cnt_model = 0;
         end else begin
            check("txn_cnt_model", 32'(txn_cnt), 32'(cnt_model));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL stream_underflow actual=%0h required=none", c);
               end else begin
                  logic [WIDTH-1:0] e;
                  e = exp_q.pop_front();
                  check("stream_c", 32'(c), 32'(e));
                  check("stream_all", 32'(c_all), 32'(&e));
                  check("stream_any", 32'(c_any), 32'(|e));
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(WIDTH'(apply_op(MAX_W'(a), MAX_W'(b), op_e'(op))));
               acc_total++;
               if (cnt_model < CNT_MAX) cnt_model++;
            end
         end
      end
   end

   typedef struct {
      logic [OP_W-1:0]  op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
      logic             all;
      logic             any;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int k;
      int start;
      bit acc;

      tbl[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1};
      tbl[1] = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b1};
      tbl[2] = '{3'd2, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b1};
      tbl[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b1};
      tbl[4] = '{3'd4, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b1};
      tbl[5] = '{3'd5, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b1};
      tbl[6] = '{3'd6, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b1};
      tbl[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0, 1'b1};
      tbl[8] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1};
      tbl[9] = '{3'd2, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0;
      tick();
      mon_en = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_c", 32'(c), 32'd0);
      check("reset_c_all", 32'(c_all), 32'd0);
      check("reset_c_any", 32'(c_any), 32'd0);
      check("reset_txn_cnt", 32'(txn_cnt), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Table of ops and reduction cases, one accept per row.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         a = tbl[i].a; b = tbl[i].b; op = tbl[i].op;
         tick();
         in_valid = 1'b0;
         check("vec_out_valid", 32'(out_valid), 32'd1);
         check("vec_c", 32'(c), 32'(tbl[i].c));
         check("vec_c_all", 32'(c_all), 32'(tbl[i].all));
         check("vec_c_any", 32'(c_any), 32'(tbl[i].any));
         if (i == 7) check("txn_after_ops", 32'(txn_cnt), 32'd8);
      end
      tick();
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Backpressure: four PASS beats 11,22,33,44 offered while stalled.
      out_ready = 1'b0;
      b = 8'hAA; op = OP_PASS;
      k = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_valid = (k < 4);
         a = 8'(8'h11 * (k + 1));
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
         check("stall_hold_c", 32'(c), 32'h11);
         check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      check("stall_accepts", 32'(k), 32'(STALL_ACC));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      for (int n = 0; n < 20 && !(k == 4 && !out_valid); n++) begin
         in_valid = (k < 4);
         a = 8'(8'h11 * (k + 1));
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
      end
      in_valid = 1'b0;
      check("release_accepts", 32'(k), 32'd4);
      check("release_drained", 32'(out_valid), 32'd0);
      check("release_queue_empty", 32'(exp_q.size()), 32'd0);

      // Saturation: 20 back-to-back accepts on a 4-bit counter.
      in_valid = 1'b1; a = 8'h55; b = 8'h0F; op = OP_AND;
      repeat (20) tick();
      in_valid = 1'b0;
      check("sat_txn_cnt", 32'(txn_cnt), 32'd15);
      tick();
      check("sat_txn_hold", 32'(txn_cnt), 32'd15);

      // Reset while a result is stalled; in_valid during reset is ignored.
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'h5A; op = OP_PASS;
      tick();
      in_valid = 1'b0;
      check("midstall_out_valid", 32'(out_valid), 32'd1);
      check("midstall_c", 32'(c), 32'h5A);
      rst = 1'b1; in_valid = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check("rststall_out_valid", 32'(out_valid), 32'd0);
      check("rststall_txn_cnt", 32'(txn_cnt), 32'd0);
      check("rststall_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("rststall_txn_after", 32'(txn_cnt), 32'd0);

      // Random stream of 1000 accepted beats.
      start = acc_total;
      for (int n = 0; n < 20000 && (acc_total - start) < 1000; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         a  = 8'($urandom);
         b  = 8'($urandom);
         op = 3'($urandom);
         tick();
      end
      check("random_accepts", 32'(acc_total - start), 32'd1000);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      check("random_drained", 32'(out_valid), 32'd0);
      check("random_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
